// File: rtl/ht_walk_ctrl.sv
// Hash-table walk controller: hashes a VPN/ASID miss to a bucket and linearly probes the table RAM.
// Optional statistics counters are built only when HT_WALK_STATS_EN is defined.
module ht_walk_ctrl #(
  parameter int VPN_W     = 20,
  parameter int ASID_W    = 10,
  parameter int PPN_W     = 20,
  parameter int ADR_W     = 10,
  parameter int MAX_PROBE = 8,
  localparam int ENT_W    = 1 + ASID_W + VPN_W + PPN_W,
  localparam int PRB_W    = $clog2(MAX_PROBE + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_i,
  input  logic [VPN_W-1:0]  req_vpn_i,
  input  logic [ASID_W-1:0] req_asid_i,
  output logic              req_rdy_o,
  input  logic              flush_i,
  input  logic              sw_req_i,
  output logic              ram_en_o,
  output logic [ADR_W-1:0]  ram_adr_o,
  input  logic [ENT_W-1:0]  ram_dat_i,
  output logic              rsp_v_o,
  input  logic              rsp_rdy_i,
  output logic              rsp_hit_o,
  output logic [PPN_W-1:0]  rsp_ppn_o,
  output logic [PRB_W-1:0]  rsp_probes_o,
  output logic [31:0]       stat_lookups_o,
  output logic [31:0]       stat_hits_o
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_CHECK = 2'd2;
  localparam logic [1:0] S_RESP  = 2'd3;

  localparam logic [PRB_W-1:0] PROBE_LIMIT = PRB_W'(MAX_PROBE);

  logic [1:0]        state, state_d;
  logic [VPN_W-1:0]  vpn_q;
  logic [ASID_W-1:0] asid_q;
  logic [ADR_W-1:0]  adr_q;
  logic [PRB_W-1:0]  probes_q;
  logic              rsp_hit_q;
  logic [PPN_W-1:0]  rsp_ppn_q;

  logic              ent_v;
  logic [ASID_W-1:0] ent_asid;
  logic [VPN_W-1:0]  ent_vpn;
  logic [PPN_W-1:0]  ent_ppn;
  logic              ent_hit;
  logic              accept;
  logic              walk_done;

  // Bucket = low VPN bits XOR the ASID, zero-extended or truncated to the address width.
  function automatic logic [ADR_W-1:0] bucket(input logic [VPN_W-1:0]  vpn,
                                              input logic [ASID_W-1:0] asid);
    logic [ADR_W-1:0] a;
    a = '0;
    for (int i = 0; i < ADR_W && i < ASID_W; i++) a[i] = asid[i];
    return vpn[ADR_W-1:0] ^ a;
  endfunction

  assign ent_v    = ram_dat_i[ENT_W-1];
  assign ent_asid = ram_dat_i[PPN_W+VPN_W +: ASID_W];
  assign ent_vpn  = ram_dat_i[PPN_W +: VPN_W];
  assign ent_ppn  = ram_dat_i[PPN_W-1:0];
  assign ent_hit  = ent_v && (ent_asid == asid_q) && (ent_vpn == vpn_q);

  assign accept    = (state == S_IDLE) && req_i && !flush_i;
  assign walk_done = ent_hit || !ent_v || (probes_q == PROBE_LIMIT);

  always_comb begin
    state_d   = state;
    req_rdy_o = 1'b0;
    ram_en_o  = 1'b0;
    case (state)
      S_IDLE: begin
        req_rdy_o = ~flush_i;
        if (accept) state_d = S_ISSUE;
      end
      S_ISSUE: begin
        // Software owns the RAM port whenever it asks; the walk just waits.
        if (!sw_req_i && !flush_i) begin
          ram_en_o = 1'b1;
          state_d  = S_CHECK;
        end
      end
      S_CHECK: state_d = walk_done ? S_RESP : S_ISSUE;
      S_RESP:  if (rsp_rdy_i) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (flush_i) state_d = S_IDLE;
  end

  assign ram_adr_o    = ram_en_o ? adr_q : '0;
  assign rsp_v_o      = (state == S_RESP);
  assign rsp_hit_o    = rsp_hit_q;
  assign rsp_ppn_o    = rsp_ppn_q;
  assign rsp_probes_o = probes_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      probes_q  <= '0;
      rsp_hit_q <= 1'b0;
      rsp_ppn_q <= '0;
    end else begin
      state <= state_d;
      if (accept)
        probes_q <= '0;
      else if (ram_en_o)
        probes_q <= probes_q + PRB_W'(1);
      if (state == S_CHECK && state_d == S_RESP) begin
        rsp_hit_q <= ent_hit;
        rsp_ppn_q <= ent_hit ? ent_ppn : '0;
      end
    end
  end

  // Request key and probe address only matter once a walk is under way.
  always_ff @(posedge clk) begin
    if (accept) begin
      vpn_q  <= req_vpn_i;
      asid_q <= req_asid_i;
      adr_q  <= bucket(req_vpn_i, req_asid_i);
    end else if (state == S_CHECK && state_d == S_ISSUE) begin
      adr_q <= adr_q + ADR_W'(1);
    end
  end

`ifdef HT_WALK_STATS_EN
  logic [31:0] lookups_q;
  logic [31:0] hits_q;
  logic        rsp_done;

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  assign rsp_done = rsp_v_o && rsp_rdy_i && !flush_i;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lookups_q <= '0;
      hits_q    <= '0;
    end else if (rsp_done) begin
      lookups_q <= sat_inc(lookups_q);
      if (rsp_hit_q) hits_q <= sat_inc(hits_q);
    end
  end

  assign stat_lookups_o = lookups_q;
  assign stat_hits_o    = hits_q;
`else
  assign stat_lookups_o = '0;
  assign stat_hits_o    = '0;
`endif

endmodule

// File: tb/tb_ht_walk_ctrl.sv
// Directed bench for ht_walk_ctrl with ADR_W=4, MAX_PROBE=4 and a behavioural one-cycle-latency RAM.
module tb_ht_walk_ctrl;

  localparam int VPN_W = 20, ASID_W = 10, PPN_W = 20, ADR_W = 4, MAX_PROBE = 4;
  localparam int ENT_W = 1 + ASID_W + VPN_W + PPN_W;
  localparam int PRB_W = 3;
  localparam int NV    = 9;

  logic              clk = 1'b0;
  logic              rst;
  logic              req_i;
  logic [VPN_W-1:0]  req_vpn_i;
  logic [ASID_W-1:0] req_asid_i;
  logic              req_rdy_o;
  logic              flush_i;
  logic              sw_req_i;
  logic              ram_en_o;
  logic [ADR_W-1:0]  ram_adr_o;
  logic [ENT_W-1:0]  ram_dat_i;
  logic              rsp_v_o;
  logic              rsp_rdy_i;
  logic              rsp_hit_o;
  logic [PPN_W-1:0]  rsp_ppn_o;
  logic [PRB_W-1:0]  rsp_probes_o;
  logic [31:0]       stat_lookups_o;
  logic [31:0]       stat_hits_o;

  ht_walk_ctrl #(.VPN_W(VPN_W), .ASID_W(ASID_W), .PPN_W(PPN_W), .ADR_W(ADR_W),
                 .MAX_PROBE(MAX_PROBE)) dut (
    .clk(clk), .rst(rst), .req_i(req_i), .req_vpn_i(req_vpn_i), .req_asid_i(req_asid_i),
    .req_rdy_o(req_rdy_o), .flush_i(flush_i), .sw_req_i(sw_req_i), .ram_en_o(ram_en_o),
    .ram_adr_o(ram_adr_o), .ram_dat_i(ram_dat_i), .rsp_v_o(rsp_v_o), .rsp_rdy_i(rsp_rdy_i),
    .rsp_hit_o(rsp_hit_o), .rsp_ppn_o(rsp_ppn_o), .rsp_probes_o(rsp_probes_o),
    .stat_lookups_o(stat_lookups_o), .stat_hits_o(stat_hits_o));

  always #5 clk = ~clk;

  logic [ENT_W-1:0] mem [16];
  always @(posedge clk) if (ram_en_o) ram_dat_i <= mem[ram_adr_o];

  typedef struct {
    logic [VPN_W-1:0]  vpn;
    logic [ASID_W-1:0] asid;
    int                stall;
    logic              hit;
    logic [PPN_W-1:0]  ppn;
    int                probes;
    logic [ADR_W-1:0]  first;
    int                lat;
  } vec_t;

  vec_t vt [NV];
  logic [ADR_W-1:0] adr_log [$];
  int total = 0;
  int bad = 0;
  int n_rsp = 0;
  int n_hit = 0;

  function automatic logic [ENT_W-1:0] ent(input logic v, input logic [ASID_W-1:0] a,
                                           input logic [VPN_W-1:0] vp, input logic [PPN_W-1:0] pp);
    return {v, a, vp, pp};
  endfunction

  function automatic vec_t mkv(input logic [VPN_W-1:0] vpn, input logic [ASID_W-1:0] asid,
                               input int stall, input logic hit, input logic [PPN_W-1:0] ppn,
                               input int probes, input logic [ADR_W-1:0] first, input int lat);
    vec_t v;
    v.vpn = vpn; v.asid = asid; v.stall = stall; v.hit = hit; v.ppn = ppn;
    v.probes = probes; v.first = first; v.lat = lat;
    return v;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  initial begin
    int   c;
    bit   done;
    bit   en_bad;
    bit   seq_ok;
    bit   saw_rsp;
    logic [ADR_W-1:0] ea;
    logic [31:0] exp_lk, exp_ht;

    for (int i = 0; i < 16; i++) mem[i] = '0;
    mem[5]  = ent(1'b1, 10'h000, 20'h00005, 20'h00ABC);
    mem[15] = ent(1'b1, 10'h000, 20'h0002F, 20'h00001);
    mem[0]  = ent(1'b1, 10'h000, 20'h00030, 20'h00002);
    mem[1]  = ent(1'b1, 10'h000, 20'h0001F, 20'h00111);
    mem[3]  = ent(1'b1, 10'h000, 20'h00043, 20'h00300);
    mem[4]  = ent(1'b1, 10'h000, 20'h00044, 20'h00400);
    mem[6]  = ent(1'b1, 10'h000, 20'h00046, 20'h00600);
    mem[7]  = ent(1'b1, 10'h000, 20'h00033, 20'h00777);
    mem[9]  = ent(1'b1, 10'h010, 20'h00009, 20'h00999);
    mem[11] = ent(1'b1, 10'h003, 20'h00008, 20'h00BBB);

    //           vpn        asid     stall hit   ppn        probes first lat
    vt[0] = mkv(20'h00005, 10'h000, 0, 1'b1, 20'h00ABC, 1, 4'h5, 3);
    vt[1] = mkv(20'h0001F, 10'h000, 0, 1'b1, 20'h00111, 3, 4'hF, 7);
    vt[2] = mkv(20'h00033, 10'h000, 0, 1'b0, 20'h00000, 4, 4'h3, 9);
    vt[3] = mkv(20'h00005, 10'h000, 3, 1'b1, 20'h00ABC, 1, 4'h5, 6);
    vt[4] = mkv(20'h00008, 10'h000, 0, 1'b0, 20'h00000, 1, 4'h8, 3);
    vt[5] = mkv(20'h00009, 10'h010, 0, 1'b1, 20'h00999, 1, 4'h9, 3);
    vt[6] = mkv(20'h00009, 10'h000, 0, 1'b0, 20'h00000, 2, 4'h9, 5);
    vt[7] = mkv(20'h00008, 10'h003, 0, 1'b1, 20'h00BBB, 1, 4'hB, 3);
    vt[8] = mkv(20'h0001F, 10'h000, 2, 1'b1, 20'h00111, 3, 4'hF, 9);

    rst = 1'b1; req_i = 1'b0; req_vpn_i = '0; req_asid_i = '0; flush_i = 1'b0;
    sw_req_i = 1'b0; rsp_rdy_i = 1'b0; ram_dat_i = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_ctrl", {req_rdy_o, ram_en_o, ram_adr_o, rsp_v_o}, {1'b1, 1'b0, 4'h0, 1'b0});
    check("reset_rsp", {rsp_hit_o, rsp_ppn_o, rsp_probes_o}, '0);
    check("reset_stats", {stat_lookups_o, stat_hits_o}, '0);
    rst = 1'b0;

    for (int i = 0; i < NV; i++) begin
      adr_log.delete();
      @(posedge clk); #1;
      rsp_rdy_i = 1'b0; req_i = 1'b1; req_vpn_i = vt[i].vpn; req_asid_i = vt[i].asid;
      sw_req_i = (vt[i].stall > 0);
      @(negedge clk);
      check($sformatf("v%0d_accept_rdy", i), {rsp_v_o, req_rdy_o}, 2'b01);
      c = 0; done = 1'b0; en_bad = 1'b0;
      while (!done && c < 60) begin
        @(posedge clk); #1;
        c++;
        req_i = 1'b0;
        sw_req_i = (c <= vt[i].stall);
        @(negedge clk);
        if (ram_en_o) begin
          adr_log.push_back(ram_adr_o);
          if (sw_req_i) en_bad = 1'b1;
        end else if (ram_adr_o != '0) begin
          en_bad = 1'b1;
        end
        if (rsp_v_o) done = 1'b1;
      end
      sw_req_i = 1'b0;
      check($sformatf("v%0d_latency", i), c, vt[i].lat);
      check($sformatf("v%0d_hit", i), rsp_hit_o, vt[i].hit);
      check($sformatf("v%0d_ppn", i), rsp_ppn_o, vt[i].ppn);
      check($sformatf("v%0d_probes", i), rsp_probes_o, vt[i].probes);
      check($sformatf("v%0d_reads", i), adr_log.size(), vt[i].probes);
      seq_ok = 1'b1;
      foreach (adr_log[k]) begin
        ea = vt[i].first + 4'(k);
        if (adr_log[k] != ea) seq_ok = 1'b0;
      end
      check($sformatf("v%0d_adr_seq", i), seq_ok, 1'b1);
      check($sformatf("v%0d_port_arb", i), en_bad, 1'b0);
      @(posedge clk); #1;
      rsp_rdy_i = 1'b1;
      @(negedge clk);
      check($sformatf("v%0d_rsp_hold", i), {req_rdy_o, rsp_v_o, rsp_hit_o, rsp_ppn_o, rsp_probes_o},
            {1'b0, 1'b1, vt[i].hit, vt[i].ppn, 3'(vt[i].probes)});
      n_rsp++;
      if (vt[i].hit) n_hit++;
    end
    @(posedge clk); #1;
    rsp_rdy_i = 1'b0;
    @(negedge clk);
    check("post_handshake_idle", {rsp_v_o, req_rdy_o}, 2'b01);

    // Flush while the first probe result is being checked.
    @(posedge clk); #1; req_i = 1'b1; req_vpn_i = 20'h00005; req_asid_i = 10'h000;
    @(posedge clk); #1; req_i = 1'b0;
    @(negedge clk);
    check("flush_chk_issue", ram_en_o, 1'b1);
    @(posedge clk); #1; flush_i = 1'b1;
    @(negedge clk);
    check("flush_chk_rdy_low", req_rdy_o, 1'b0);
    @(posedge clk); #1; flush_i = 1'b0;
    @(negedge clk);
    check("flush_chk_idle", {rsp_v_o, req_rdy_o}, 2'b01);
    saw_rsp = 1'b0;
    repeat (4) begin
      @(negedge clk);
      if (rsp_v_o || ram_en_o) saw_rsp = 1'b1;
    end
    check("flush_chk_no_rsp", saw_rsp, 1'b0);

    // Flush together with a request in IDLE: request must be refused.
    @(posedge clk); #1; req_i = 1'b1; flush_i = 1'b1; req_vpn_i = 20'h00005;
    @(negedge clk);
    check("flush_idle_rdy", req_rdy_o, 1'b0);
    @(posedge clk); #1; req_i = 1'b0; flush_i = 1'b0;
    @(negedge clk);
    check("flush_idle_not_taken", {ram_en_o, req_rdy_o}, 2'b01);

    // Flush while a response is pending: it disappears the next cycle, unacknowledged.
    @(posedge clk); #1; req_i = 1'b1; req_vpn_i = 20'h00005; req_asid_i = 10'h000;
    @(posedge clk); #1; req_i = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    @(negedge clk);
    check("flush_resp_pending", {rsp_v_o, rsp_hit_o}, 2'b11);
    @(posedge clk); #1; flush_i = 1'b1;
    @(negedge clk);
    check("flush_resp_still_v", rsp_v_o, 1'b1);
    @(posedge clk); #1; flush_i = 1'b0;
    @(negedge clk);
    check("flush_resp_dropped", {rsp_v_o, req_rdy_o}, 2'b01);

`ifdef HT_WALK_STATS_EN
    exp_lk = n_rsp;
    exp_ht = n_hit;
`else
    exp_lk = 32'd0;
    exp_ht = 32'd0;
`endif
    check("stat_lookups", stat_lookups_o, exp_lk);
    check("stat_hits", stat_hits_o, exp_ht);

    // Asynchronous reset in the middle of a walk.
    @(posedge clk); #1; req_i = 1'b1; req_vpn_i = 20'h0001F; req_asid_i = 10'h000;
    @(posedge clk); #1; req_i = 1'b0;
    #1 rst = 1'b1;
    #1;
    check("rst_mid_walk", {req_rdy_o, ram_en_o, rsp_v_o, rsp_probes_o}, {1'b1, 1'b0, 1'b0, 3'd0});
    check("rst_mid_stats", {stat_lookups_o, stat_hits_o}, '0);
    @(negedge clk); rst = 1'b0;
    saw_rsp = 1'b0;
    repeat (8) begin
      @(negedge clk);
      if (rsp_v_o || ram_en_o) saw_rsp = 1'b1;
    end
    check("rst_no_rsp", saw_rsp, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
